// File: rtl/fret_sequencer.sv
// fret_sequencer: walks a table of fret entries in data memory. Each entry holds
// {flags[3:0], duration[11:0]}. Each entry's duration is counted in ticks of
// TICK_DIV clocks. A zero duration ends the sequence.
// Optional build macro FRET_SEQ_LOOP_EN: the end of the last fret wraps back to
// entry 0 instead of finishing.
module fret_sequencer #(
    parameter logic [15:0] BASE_ADDR = 16'hF000,
    parameter int unsigned NUM_FRETS = 20,
    parameter int unsigned TICK_DIV  = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    output logic [15:0] mem_addr,
    input  logic [15:0] mem_data,
    output logic [4:0]  fret_idx,
    output logic [3:0]  fret_flags,
    output logic        fret_active,
    output logic        fret_strobe,
    output logic        busy,
    output logic        done
);

    localparam int unsigned    PW         = $clog2(TICK_DIV);
    localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [4:0]     IDX_LAST   = 5'(NUM_FRETS - 1);

    typedef enum logic [2:0] {StIdle, StFetch, StWait, StCount, StDone} state_e;

    state_e         r_state;
    logic [4:0]     r_idx;
    logic [15:0]    r_mem_addr;
    logic [4:0]     r_fret_idx;
    logic [3:0]     r_fret_flags;
    logic [11:0]    r_dur;
    logic [PW-1:0]  r_presc;
    logic           r_active;
    logic           r_strobe;
    logic           r_busy;
    logic           r_done;

    logic           w_wrap;
    logic           w_last;
    logic [15:0]    w_next_addr;

    assign w_wrap      = (r_presc == PRESC_LAST);
    assign w_last      = (r_idx == IDX_LAST);
    // 16-bit add, wraps modulo 2^16 past the top of memory
    assign w_next_addr = BASE_ADDR + {11'd0, r_idx} + 16'd1;

    // Sequencer FSM with all outputs registered alongside the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= StIdle;
            r_idx        <= 5'd0;
            r_mem_addr   <= BASE_ADDR;
            r_fret_idx   <= 5'd0;
            r_fret_flags <= 4'd0;
            r_dur        <= 12'd0;
            r_presc      <= '0;
            r_active     <= 1'b0;
            r_strobe     <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_strobe <= 1'b0;
            r_done   <= 1'b0;
            if (stop && (r_state != StIdle)) begin
                // Abort: no done pulse
                r_state  <= StIdle;
                r_active <= 1'b0;
                r_busy   <= 1'b0;
            end else begin
                case (r_state)
                    StIdle: begin
                        if (start && !stop) begin
                            r_state    <= StFetch;
                            r_idx      <= 5'd0;
                            r_mem_addr <= BASE_ADDR;
                            r_busy     <= 1'b1;
                        end
                    end
                    StFetch: r_state <= StWait;
                    StWait: begin
                        r_dur        <= mem_data[11:0];
                        r_fret_flags <= mem_data[15:12];
                        if (mem_data[11:0] == 12'd0) begin
                            r_state <= StDone;
                            r_done  <= 1'b1;
                        end else begin
                            r_state    <= StCount;
                            r_fret_idx <= r_idx;
                            r_strobe   <= 1'b1;
                            r_presc    <= '0;
                            r_active   <= 1'b1;
                        end
                    end
                    StCount: begin
                        if (w_wrap) begin
                            r_presc <= '0;
                            r_dur   <= r_dur - 12'd1;
                            if (r_dur == 12'd1) begin
                                r_active <= 1'b0;
                                if (!w_last) begin
                                    r_idx      <= r_idx + 5'd1;
                                    r_mem_addr <= w_next_addr;
                                    r_state    <= StFetch;
                                end else begin
`ifdef FRET_SEQ_LOOP_EN
                                    r_idx      <= 5'd0;
                                    r_mem_addr <= BASE_ADDR;
                                    r_state    <= StFetch;
`else
                                    r_state    <= StDone;
                                    r_done     <= 1'b1;
`endif
                                end
                            end
                        end else begin
                            r_presc <= r_presc + PW'(1);
                        end
                    end
                    StDone: begin
                        r_state <= StIdle;
                        r_busy  <= 1'b0;
                    end
                    default: begin
                        r_state  <= StIdle;
                        r_active <= 1'b0;
                        r_busy   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign mem_addr    = r_mem_addr;
    assign fret_idx    = r_fret_idx;
    assign fret_flags  = r_fret_flags;
    assign fret_active = r_active;
    assign fret_strobe = r_strobe;
    assign busy        = r_busy;
    assign done        = r_done;

endmodule

// File: tb/tb_fret_sequencer.sv
// tb_fret_sequencer: directed bench for fret_sequencer with TICK_DIV=4, NUM_FRETS=3.
// Compile with FRET_SEQ_LOOP_EN defined to exercise the looping build.
module tb_fret_sequencer;

    logic        clk = 1'b0;
    logic        reset, start, stop;
    logic [15:0] mem_addr, mem_data;
    logic [4:0]  fret_idx;
    logic [3:0]  fret_flags;
    logic        fret_active, fret_strobe, busy, done;

    always #5 clk = ~clk;

    fret_sequencer #(
        .BASE_ADDR (16'hF000),
        .NUM_FRETS (3),
        .TICK_DIV  (4)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .stop        (stop),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .fret_idx    (fret_idx),
        .fret_flags  (fret_flags),
        .fret_active (fret_active),
        .fret_strobe (fret_strobe),
        .busy        (busy),
        .done        (done)
    );

    // Registered-read memory: data valid one cycle after the address is sampled.
    logic [15:0] mem [0:3];
    always @(posedge clk) begin
        if (mem_addr >= 16'hF000 && mem_addr < 16'hF004) mem_data <= mem[mem_addr[1:0]];
        else mem_data <= 16'hDEAD;
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [15:0]      e0, e1, e2;
        bit               term;     // ends via terminator (valid in looping build too)
        int               n_str;
        logic [2:0][4:0]  s_idx;
        logic [2:0][3:0]  s_flg;
        logic [2:0][7:0]  s_cyc;
        logic [2:0][7:0]  s_len;
        int               done_c;
        logic [3:0]       fin_flags;
        logic [4:0]       fin_idx;
    } vec_t;

    vec_t vecs[4];

    task automatic do_reset();
        reset = 1'b1; start = 1'b0; stop = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic load(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
        mem[0] = a; mem[1] = b; mem[2] = c; mem[3] = 16'h0000;
    endtask

    // Leaves the caller on the negedge of cycle 1 (first cycle after acceptance).
    task automatic start_pulse();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_strobe(input logic [4:0] want, output bit found);
        found = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (fret_strobe && fret_idx == want) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    task automatic run_vec(input int k, input vec_t v);
        int ns, nl, cur, dn, dc, idle_c;
        bit ended;
        logic [2:0][4:0] sidx;
        logic [2:0][3:0] sflg;
        logic [2:0][7:0] scyc, lens;
        logic [3:0] ffl;
        logic [4:0] fid;
        ns = 0; nl = 0; cur = 0; dn = 0; dc = -1; idle_c = -1; ended = 1'b0;
        sidx = '0; sflg = '0; scyc = '0; lens = '0; ffl = '0; fid = '0;
        do_reset();
        load(v.e0, v.e1, v.e2);
        start_pulse();
        for (int c = 1; c <= 100; c++) begin
            if (c == 1) begin
                chk($sformatf("v%0d_busy_c1", k), busy, 1);
                chk($sformatf("v%0d_addr_c1", k), mem_addr, 16'hF000);
            end
            if (fret_strobe) begin
                if (ns < 3) begin
                    sidx[ns] = fret_idx; sflg[ns] = fret_flags; scyc[ns] = 8'(c);
                end
                ns++;
            end
            if (fret_active) cur++;
            else if (cur > 0) begin
                if (nl < 3) lens[nl] = 8'(cur);
                nl++;
                cur = 0;
            end
            if (done) begin
                dn++; dc = c; ffl = fret_flags; fid = fret_idx;
            end
            if (!busy) begin
                idle_c = c;
                ended = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk($sformatf("v%0d_terminated", k), ended, 1);
        chk($sformatf("v%0d_strobes", k), ns, v.n_str);
        chk($sformatf("v%0d_active_runs", k), nl, v.n_str);
        for (int i = 0; i < v.n_str && i < 3; i++) begin
            chk($sformatf("v%0d_s%0d_idx", k, i), sidx[i], v.s_idx[i]);
            chk($sformatf("v%0d_s%0d_flags", k, i), sflg[i], v.s_flg[i]);
            chk($sformatf("v%0d_s%0d_cycle", k, i), scyc[i], v.s_cyc[i]);
            chk($sformatf("v%0d_s%0d_len", k, i), lens[i], v.s_len[i]);
        end
        chk($sformatf("v%0d_done_count", k), dn, 1);
        chk($sformatf("v%0d_done_cycle", k), dc, v.done_c);
        chk($sformatf("v%0d_idle_after_done", k), idle_c, v.done_c + 1);
        chk($sformatf("v%0d_final_flags", k), ffl, v.fin_flags);
        chk($sformatf("v%0d_final_idx", k), fid, v.fin_idx);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        int cnt_done, cnt_busy;

        vecs[0] = '{e0:16'h0002, e1:16'h5001, e2:16'h0003, term:1'b0, n_str:3,
                    s_idx:{5'd2, 5'd1, 5'd0}, s_flg:{4'd0, 4'd5, 4'd0},
                    s_cyc:{8'd19, 8'd13, 8'd3}, s_len:{8'd12, 8'd4, 8'd8},
                    done_c:31, fin_flags:4'd0, fin_idx:5'd2};
        vecs[1] = '{e0:16'h0002, e1:16'h7000, e2:16'h0003, term:1'b1, n_str:1,
                    s_idx:{5'd0, 5'd0, 5'd0}, s_flg:{4'd0, 4'd0, 4'd0},
                    s_cyc:{8'd0, 8'd0, 8'd3}, s_len:{8'd0, 8'd0, 8'd8},
                    done_c:13, fin_flags:4'd7, fin_idx:5'd0};
        vecs[2] = '{e0:16'h9000, e1:16'h5001, e2:16'h0003, term:1'b1, n_str:0,
                    s_idx:'0, s_flg:'0, s_cyc:'0, s_len:'0,
                    done_c:3, fin_flags:4'd9, fin_idx:5'd0};
        vecs[3] = '{e0:16'h1001, e1:16'h2001, e2:16'h3001, term:1'b0, n_str:3,
                    s_idx:{5'd2, 5'd1, 5'd0}, s_flg:{4'd3, 4'd2, 4'd1},
                    s_cyc:{8'd15, 8'd9, 8'd3}, s_len:{8'd4, 8'd4, 8'd4},
                    done_c:19, fin_flags:4'd3, fin_idx:5'd2};

        // Reset state, with start asserted to show reset dominates
        load(16'h0002, 16'h5001, 16'h0003);
        reset = 1'b1; start = 1'b1; stop = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_addr", mem_addr, 16'hF000);
        chk("rst_idx", fret_idx, 0);
        chk("rst_flags", fret_flags, 0);
        chk("rst_active", fret_active, 0);
        chk("rst_strobe", fret_strobe, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        start = 1'b0;

        // Table-driven full runs
        for (int k = 0; k < 4; k++) begin
`ifdef FRET_SEQ_LOOP_EN
            if (vecs[k].term) run_vec(k, vecs[k]);
`else
            run_vec(k, vecs[k]);
`endif
        end

        // Start while busy is ignored, then stop mid-fret 1 aborts without done
        do_reset();
        load(16'h0002, 16'h5001, 16'h0003);
        start_pulse();
        wait_strobe(5'd1, found);
        chk("stop_found_fret1", found, 1);
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        chk("busy_start_active", fret_active, 1);
        chk("busy_start_strobe", fret_strobe, 0);
        chk("busy_start_idx", fret_idx, 1);
        stop = 1'b1;
        @(negedge clk) stop = 1'b0;
        chk("stop_busy", busy, 0);
        chk("stop_active", fret_active, 0);
        chk("stop_done", done, 0);
        cnt_done = 0; cnt_busy = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) cnt_done++;
            if (busy) cnt_busy++;
        end
        chk("stop_no_late_done", cnt_done, 0);
        chk("stop_stays_idle", cnt_busy, 0);

        // start and stop together in IDLE: stop wins
        do_reset();
        @(negedge clk) begin start = 1'b1; stop = 1'b1; end
        @(negedge clk) begin start = 1'b0; stop = 1'b0; end
        chk("start_stop_idle", busy, 0);
        @(negedge clk);
        chk("start_stop_idle2", busy, 0);

        // Reset mid-COUNT of fret 1 (flags 5) returns every output to reset values
        do_reset();
        load(16'h0002, 16'h5001, 16'h0003);
        start_pulse();
        wait_strobe(5'd1, found);
        chk("mrst_found_fret1", found, 1);
        @(negedge clk);
        chk("mrst_pre_flags", fret_flags, 5);
        reset = 1'b1; start = 1'b1;
        @(negedge clk);
        chk("mrst_addr", mem_addr, 16'hF000);
        chk("mrst_idx", fret_idx, 0);
        chk("mrst_flags", fret_flags, 0);
        chk("mrst_active", fret_active, 0);
        chk("mrst_strobe", fret_strobe, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_done", done, 0);
        reset = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("mrst_idle_after", busy, 0);

`ifdef FRET_SEQ_LOOP_EN
        // Looping build: after fret 2 the table restarts at entry 0 without done
        begin
            bit saw_base, saw_s0;
            int dist;
            do_reset();
            load(16'h0002, 16'h5001, 16'h0003);
            start_pulse();
            wait_strobe(5'd2, found);
            chk("loop_found_fret2", found, 1);
            saw_base = 1'b0; saw_s0 = 1'b0; dist = -1; cnt_done = 0;
            for (int c = 1; c <= 40; c++) begin
                @(negedge clk);
                if (done) cnt_done++;
                if (busy && !fret_active && mem_addr == 16'hF000) saw_base = 1'b1;
                if (fret_strobe && fret_idx == 5'd0) begin
                    saw_s0 = 1'b1;
                    dist = c;
                    break;
                end
            end
            chk("loop_addr_base", saw_base, 1);
            chk("loop_strobe_idx0", saw_s0, 1);
            chk("loop_strobe_dist", dist, 14);
            chk("loop_no_done", cnt_done, 0);
            chk("loop_flags", fret_flags, 0);
            stop = 1'b1;
            @(negedge clk) stop = 1'b0;
            chk("loop_stop_busy", busy, 0);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fret_sequencer.md
FRET_SEQUENCER -- requirements
Module: fret_sequencer

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 16'hF000, word address of fret entry 0 in data memory.
REQ-002 SHALL have parameter NUM_FRETS, default 20, number of fret entries (1..31).
REQ-003 SHALL have parameter TICK_DIV, default 50000, clk cycles per duration tick (>=2).
REQ-004 clk  input  1  single clock; all logic on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  one-cycle request to play the fret table from entry 0.
REQ-007 stop  input  1  one-cycle abort request.
REQ-008 mem_addr  output  16  read address, wired to the memory read port (port B, write enable tied low).
REQ-009 mem_data  input  16  read data from that port; registered, valid 1 cycle after mem_addr is sampled.
REQ-010 fret_idx  output  5  index of current fret (0-based).
REQ-011 fret_flags  output  4  mem_data[15:12] of current entry.
REQ-012 fret_active  output  1  high while a fret duration is counting.
REQ-013 fret_strobe  output  1  one-cycle pulse on the first cycle of each fret.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 done  output  1  one-cycle pulse when the sequence ends, whether at the end of the table or at a terminator.

Function
REQ-016 FSM states SHALL be IDLE, FETCH, WAIT, COUNT, DONE.
REQ-017 IDLE: start=1 and stop=0 -> FETCH, idx<=0, mem_addr<=BASE_ADDR.
REQ-018 FETCH -> WAIT unconditionally; the memory samples mem_addr on this edge.
REQ-019 WAIT: data is valid on mem_data; on this edge the block SHALL capture dur<=mem_data[11:0] and fret_flags<=mem_data[15:12].
REQ-020 WAIT: mem_data[11:0]==0 is a terminator -> DONE, no strobe, fret_idx unchanged.
REQ-021 WAIT: nonzero duration -> COUNT, fret_idx<=idx, fret_strobe=1 for the next cycle only, prescaler<=0.
REQ-022 COUNT: prescaler SHALL count 0..TICK_DIV-1 and wrap; on wrap dur<=dur-1.
REQ-023 COUNT: wrap with dur==1 ends the fret, so each fret occupies exactly dur*TICK_DIV cycles in COUNT.
REQ-024 End of fret with idx<NUM_FRETS-1 -> idx<=idx+1, mem_addr<=BASE_ADDR+idx+1, next state FETCH.
REQ-025 End of fret with idx==NUM_FRETS-1 -> DONE (see REQ-033 for the loop variant).
REQ-026 DONE SHALL assert done for one cycle, then go to IDLE.
REQ-027 Start-of-fret latency: start accepted on edge E0 -> fret_strobe high in the cycle after edge E2.
REQ-028 fret_active SHALL be high exactly in COUNT.
REQ-029 stop=1 in any non-IDLE state -> IDLE on the next edge; done is not pulsed and fret_active drops.
REQ-030 start while busy SHALL be ignored; start and stop together in IDLE -> stop wins, stay in IDLE.
REQ-031 mem_addr arithmetic SHALL be 16-bit and wrap modulo 2^16.

Reset
REQ-032 While reset=1: state<=IDLE, mem_addr<=BASE_ADDR, fret_idx<=0, fret_flags<=0, dur<=0, prescaler<=0, and all 1-bit outputs <=0; reset overrides start and stop, including mid-sequence.

Configuration
REQ-033 Macro FRET_SEQ_LOOP_EN: when defined, the end of the last fret SHALL wrap to idx<=0, mem_addr<=BASE_ADDR, next state FETCH, with no done pulse; only stop, reset or a terminator ends the sequence. When undefined, REQ-025 applies.

Verification (TICK_DIV=4, NUM_FRETS=3, entries 16'h0002, 16'h5001, 16'h0003)
REQ-034 start pulse at cycle 0 -> mem_addr=F000; fret_strobe at cycle 3 with fret_idx=0, fret_flags=0; fret_active held for 8 cycles.
REQ-035 Full run, macro undefined -> strobes with fret_idx 0/1/2 (fret_flags 0/5/0), active lengths 8/4/12, done 1 cycle, then busy=0.
REQ-036 Entry 1 set to 16'h7000 -> done pulses after fret 0, no strobe for idx 1, and fret_flags=7 at completion.
REQ-037 stop during fret 1 COUNT -> busy=0 on the next cycle, no done; a start pulse while busy has no effect on the sequence.
REQ-038 FRET_SEQ_LOOP_EN defined -> after idx 2, mem_addr returns to F000 and a strobe with fret_idx=0 follows, no done; reset mid-COUNT -> every output at its reset value one cycle later.
